// File: rtl/jt89_pkg.sv
// rtl/jt89_pkg.sv - shared register indices, latch byte layout and write-FSM states for jt89
package jt89_pkg;

    localparam logic [2:0] TONE0 = 3'd0;
    localparam logic [2:0] VOL0  = 3'd1;
    localparam logic [2:0] TONE1 = 3'd2;
    localparam logic [2:0] VOL1  = 3'd3;
    localparam logic [2:0] TONE2 = 3'd4;
    localparam logic [2:0] VOL2  = 3'd5;
    localparam logic [2:0] NOISE = 3'd6;
    localparam logic [2:0] VOL3  = 3'd7;

    localparam int LATCH_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LOW   = 2'd2,
        ST_GAP   = 2'd3
    } wr_state_e;

    function automatic logic is_tone(input logic [2:0] r);
        return (r == TONE0) || (r == TONE1) || (r == TONE2);
    endfunction

    function automatic logic [1:0] tone_ch(input logic [2:0] r);
        case (r)
            TONE1:   tone_ch = 2'd1;
            TONE2:   tone_ch = 2'd2;
            default: tone_ch = 2'd0;
        endcase
    endfunction

    // Noise control only carries 3 bits; bit 3 of its latch nibble must stay 0.
    function automatic logic [3:0] lo_nibble(input logic [2:0] r, input logic [9:0] v);
        case (r)
            NOISE:                  lo_nibble = {1'b0, v[2:0]};
            VOL0, VOL1, VOL2, VOL3: lo_nibble = v[3:0];
            default:                lo_nibble = v[3:0];
        endcase
    endfunction

endpackage

// File: rtl/jt89_wr_fifo.sv
// rtl/jt89_wr_fifo.sv - synchronous first-word-fall-through request FIFO
module jt89_wr_fifo #(
    parameter int AW = 2,
    parameter int W  = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic         push_ok;
    logic         pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/jt89_wr.sv
// rtl/jt89_wr.sv - queues register requests and serialises them into SN76489 byte writes
module jt89_wr
    import jt89_pkg::*;
#(
    parameter int WR_LOW = 4,
    parameter int WR_GAP = 4,
    parameter int AW     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_reg,
    input  logic [9:0] req_val,
    output logic [7:0] dout,
    output logic       wr_n,
    output logic       busy
);

    localparam int CMAX = (WR_LOW > WR_GAP) ? WR_LOW : WR_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LOW_LAST = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(WR_GAP - 1);

    wr_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    dout_q;
    logic          wr_n_q;
    logic [7:0]    data_q;
    logic          pend_q;
    logic [2:0]    hi_v_q;
    logic [5:0]    hi_sh_q [3];

    logic [12:0]   head;
    logic          empty;
    logic          full;
    logic          pop;
    logic [2:0]    head_reg;
    logic [9:0]    head_val;
    logic [7:0]    latch_d;
    logic [7:0]    data_d;
    logic [1:0]    ch_d;
    logic          need_data_d;

    assign pop       = (state_q == ST_IDLE) && !empty;
    assign head_reg  = head[12:10];
    assign head_val  = head[9:0];
    assign req_ready = !full;
    assign busy      = !empty || (state_q != ST_IDLE);
    assign dout      = dout_q;
    assign wr_n      = wr_n_q;

    jt89_wr_fifo #(
        .AW (AW),
        .W  (13)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_valid),
        .wdata_i ({req_reg, req_val}),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (empty),
        .full_o  (full)
    );

    // The data byte is skipped when the chip already holds these tone high bits.
    always_comb begin
        latch_d            = '0;
        latch_d[LATCH_BIT] = 1'b1;
        latch_d[6:4]       = head_reg;
        latch_d[3:0]       = lo_nibble(head_reg, head_val);
        data_d             = {2'b00, head_val[9:4]};
        ch_d               = tone_ch(head_reg);
        need_data_d        = is_tone(head_reg) &&
                             !(hi_v_q[ch_d] && (hi_sh_q[ch_d] == head_val[9:4]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= 8'h00;
            wr_n_q  <= 1'b1;
            data_q  <= 8'h00;
            pend_q  <= 1'b0;
            hi_v_q  <= '0;
            for (int i = 0; i < 3; i++) hi_sh_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        dout_q  <= latch_d;
                        data_q  <= data_d;
                        pend_q  <= need_data_d;
                        if (is_tone(head_reg)) begin
                            hi_sh_q[ch_d] <= head_val[9:4];
                            hi_v_q[ch_d]  <= 1'b1;
                        end
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    wr_n_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_LOW;
                end
                ST_LOW: begin
                    if (clk_en) begin
                        if (cnt_q == LOW_LAST) begin
                            cnt_q   <= '0;
                            wr_n_q  <= 1'b1;
                            state_q <= ST_GAP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (clk_en) begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_q <= '0;
                            if (pend_q) begin
                                pend_q  <= 1'b0;
                                dout_q  <= data_q;
                                state_q <= ST_SETUP;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/jt89_wr.md
# jt89_wr

Bus-side write sequencer for the jt89 PSG. It accepts register-level requests (register index plus 10-bit value) through a valid/ready port and queues them in a small FIFO. Each request is serialised into the SN76489 one- or two-byte write protocol on `dout`/`wr_n`, with programmable strobe width and inter-byte gap. Shadow copies of the tone high bits let the block skip the data byte when only the low nibble changes. It sits between a CPU/sound-driver side and a jt89 instance.

## Interface
- `WR_LOW`, 4: `wr_n` low duration, in `clk_en` pulses (≥1).
- `WR_GAP`, 4: `wr_n` high time after each byte, in `clk_en` pulses (≥1).
- `AW`, 2: FIFO address width; depth = 2^AW entries.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `clk_en` in 1: pacing enable; only the LOW and GAP counters advance on it.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO not full.
- `req_reg` in 3: PSG register index.
  - 0/2/4 = tone0/1/2.
  - 1/3/5/7 = vol0/1/2/3.
  - 6 = noise ctrl.
- `req_val` in 10: value.
  - Tone uses [9:0].
  - Volume uses [3:0].
  - Noise ctrl uses [2:0].
  - Unused bits are ignored.
- `dout` out 8: PSG data bus.
- `wr_n` out 1: active-low write strobe.
- `busy` out 1: high when the FIFO is non-empty or the FSM is not in IDLE.

## Operation
- Push on `req_valid & req_ready`. `req_ready` equals `!full`, from registered pointers.
- Byte encoding:
  - Latch byte = {1, req_reg, lo}.
  - lo = `req_val[3:0]` for tone and volume; lo = {0, `req_val[2:0]`} for noise ctrl.
  - Data byte (tone only) = {00, `req_val[9:4]`}.
- Shadows: per tone channel, `hi_sh[5:0]` plus a valid bit `hi_v`.
  - On pop of a tone entry: if `hi_v` is set and `req_val[9:4]` equals `hi_sh`, send the latch byte only.
  - Otherwise send latch then data, and set `hi_sh`/`hi_v`.
  - Volume and noise entries are always a single byte.
- FSM states: IDLE, SETUP, LOW, GAP.
  - IDLE: if FIFO non-empty, pop, compute bytes, go to SETUP.
  - SETUP: exactly 1 clk. `dout` = current byte, `wr_n` = 1. Go to LOW.
  - LOW: `wr_n` = 0. Count `WR_LOW` `clk_en` pulses, then go to GAP.
  - GAP: `wr_n` = 1. Count `WR_GAP` pulses. Then go to SETUP with the data byte if one is pending, otherwise IDLE.
- `dout` holds its last byte until the next SETUP.
- Requests are issued strictly in FIFO order. Nothing is dropped or merged.
- Reset values: `wr_n` = 1, `dout` = 0x00, `req_ready` = 1, `busy` = 0, FIFO empty, all `hi_v` = 0, state IDLE.
- Reset mid-transfer: in the cycle after `rst` is sampled, `wr_n` = 1. The queue is flushed, so any pending data byte is lost. Shadows are invalidated, so the next tone write always sends two bytes.

## Timing
- With `clk_en` = 1 and an empty queue:
  - Handshake in cycle 0.
  - FIFO non-empty in cycle 1; IDLE pops.
  - SETUP in cycle 2, `dout` valid.
  - `wr_n` low in cycles 3..2+`WR_LOW`.
  - GAP for `WR_GAP` cycles.
- Byte throughput: 1 + `WR_LOW` + `WR_GAP` cycles per byte, plus 1 IDLE cycle between entries.
- `dout` is stable from SETUP through the end of GAP. The jt89 samples `din` on the first clk it sees `wr_n` low, so setup of ≥1 clk is guaranteed.
- Simultaneous push and pop is allowed when not full. At full, `req_ready` is already low.
- Push while full is ignored, since `req_valid` without `req_ready` is not a transfer.

## Structure
- A shared `jt89_pkg` holds:
  - register index localparams (TONE0=0 … VOL3=7, NOISE=6);
  - latch bit position;
  - FSM state encoding.
- Sub-module `jt89_wr_fifo`: synchronous FIFO, width 13 ({reg, val}), depth 2^AW, outputs `empty`/`full`, first-word-fall-through output.
- The top level holds the FSM, counters, shadows and byte mux.

## Test plan
- Volume: `req_reg` = 3, `req_val` = 5, `clk_en` = 1 → single byte 0xB5, `wr_n` low cycles 3–6, `busy` drops after GAP + IDLE.
- Tone shadow on channel 0:
  - `req_val` 0x3FE → 0x8E then 0x3F.
  - Then 0x3F1 → 0x81 only.
  - Then 0x2F1 → 0x81, 0x2F.
- Noise ctrl: `req_reg` = 6, `req_val` = 0x3F5 → single byte 0xE5. A co-simulated jt89 sees ctrl3 = 5 and a noise clear pulse.
- Back-pressure, AW = 2: 7 back-to-back volume requests → `req_ready` deasserts once 4 entries are queued, all 7 bytes are emitted in order, none lost.
- Pacing: `clk_en` 1-in-3, `WR_LOW` = 4 → `wr_n` low for 12 clk; SETUP is still 1 clk.
- Reset during LOW of a tone latch byte → `wr_n` = 1 next cycle, queue empty. A new tone0 write of 0x3FE sends two bytes again. jt89 registers match the driven values.
